// File: rtl/ball_move_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | ball_pkg: shared FSM/direction types and HID keycode constants      |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

package ball_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    CHECK  = 2'd2,
    MOVE   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  function automatic dir_t key_to_dir(input logic [7:0] code);
    dir_t d;
    d = NONE;
    case (code)
      KEY_W:   d = UP;
      KEY_S:   d = DOWN;
      KEY_A:   d = LEFT;
      KEY_D:   d = RIGHT;
      default: d = NONE;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ball_move_ctrl_key_decode.sv
// +--------------------------------------------------------------------+
// | ball_key_decode: two HID usage codes -> one direction, low byte wins |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module ball_key_decode
  import ball_pkg::*;
(
  input  logic [15:0] keycode,
  output dir_t        dir
);

  dir_t lo_dir;
  dir_t hi_dir;

  always_comb begin
    lo_dir = key_to_dir(keycode[7:0]);
    hi_dir = key_to_dir(keycode[15:8]);
    dir    = (lo_dir != NONE) ? lo_dir : hi_dir;
  end

endmodule

`default_nettype wire

// File: rtl/ball_move_ctrl.sv
// +--------------------------------------------------------------------+
// | ball_move_ctrl: per-frame ball movement with wall-query handshake    |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module ball_move_ctrl
  import ball_pkg::*;
#(
  parameter logic [9:0] X_START     = 10'd320,
  parameter logic [9:0] Y_START     = 10'd240,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479,
  parameter logic [9:0] STEP        = 10'd2,
  parameter logic [9:0] EXIT_X      = 10'd620,
  parameter logic [4:0] ACK_TIMEOUT = 5'd16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_vs,
  input  logic [15:0] keycode,
  output logic        wall_req,
  output logic [9:0]  wall_x,
  output logic [9:0]  wall_y,
  input  logic        wall_ack,
  input  logic        wall_hit,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [1:0]  map,
  output logic        busy,
  output logic        frame_miss,
  output logic        wall_timeout
);

  state_t      state_q, state_d;
  logic        vs_q, vs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  cand_x_q, cand_x_d;
  logic [9:0]  cand_y_q, cand_y_d;
  logic [9:0]  ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic [1:0]  map_q, map_d;
  logic        frame_miss_q, frame_miss_d;
  logic        wall_timeout_q, wall_timeout_d;

  logic        tick;
  dir_t        dir;

  ball_key_decode u_key_decode (
    .keycode (keycode),
    .dir     (dir)
  );

  assign tick = vs_q & ~frame_vs;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      vs_q           <= 1'b1;
      cnt_q          <= '0;
      cand_x_q       <= '0;
      cand_y_q       <= '0;
      ball_x_q       <= X_START;
      ball_y_q       <= Y_START;
      map_q          <= '0;
      frame_miss_q   <= 1'b0;
      wall_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_q           <= vs_d;
      cnt_q          <= cnt_d;
      cand_x_q       <= cand_x_d;
      cand_y_q       <= cand_y_d;
      ball_x_q       <= ball_x_d;
      ball_y_q       <= ball_y_d;
      map_q          <= map_d;
      frame_miss_q   <= frame_miss_d;
      wall_timeout_q <= wall_timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    vs_d           = frame_vs;
    cnt_d          = cnt_q;
    cand_x_d       = cand_x_q;
    cand_y_d       = cand_y_q;
    ball_x_d       = ball_x_q;
    ball_y_d       = ball_y_q;
    map_d          = map_q;
    // Ticks are never queued: anything arriving outside IDLE is reported and lost.
    frame_miss_d   = tick & (state_q != IDLE);
    wall_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        cnt_d    = '0;
        cand_x_d = ball_x_q;
        cand_y_d = ball_y_q;
        case (dir)
          UP:      cand_y_d = (ball_y_q < STEP) ? 10'd0 : ball_y_q - STEP;
          DOWN:    cand_y_d = (ball_y_q > Y_MAX - STEP) ? Y_MAX : ball_y_q + STEP;
          LEFT:    cand_x_d = (ball_x_q < STEP) ? 10'd0 : ball_x_q - STEP;
          RIGHT:   cand_x_d = (ball_x_q > X_MAX - STEP) ? X_MAX : ball_x_q + STEP;
          default: begin
            cand_x_d = cand_x_q;
            cand_y_d = cand_y_q;
          end
        endcase
        state_d = (dir == NONE) ? IDLE : CHECK;
      end

      CHECK: begin
        cnt_d = cnt_q + 5'd1;
        if (wall_ack) begin
          state_d = wall_hit ? IDLE : MOVE;
        end else if (cnt_d == ACK_TIMEOUT) begin
          wall_timeout_d = 1'b1;
          state_d        = IDLE;
        end
      end

      MOVE: begin
        if (cand_x_q >= EXIT_X) begin
          map_d    = map_q + 2'd1;
          ball_x_d = X_START;
          ball_y_d = Y_START;
        end else begin
          ball_x_d = cand_x_q;
          ball_y_d = cand_y_q;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign wall_req     = (state_q == CHECK);
  assign wall_x       = cand_x_q;
  assign wall_y       = cand_y_q;
  assign BallX        = ball_x_q;
  assign BallY        = ball_y_q;
  assign map          = map_q;
  assign busy         = (state_q != IDLE);
  assign frame_miss   = frame_miss_q;
  assign wall_timeout = wall_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_move_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_ball_move_ctrl: frame-level reference model checked every cycle   |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ball_move_ctrl;

  logic        Clk      = 1'b0;
  logic        Reset    = 1'b1;
  logic        frame_vs = 1'b1;
  logic [15:0] keycode  = 16'h0000;
  logic        wall_ack = 1'b0;
  logic        wall_hit = 1'b0;
  logic        wall_req, busy, frame_miss, wall_timeout;
  logic [9:0]  wall_x, wall_y, BallX, BallY;
  logic [1:0]  map;

  always #5 Clk = ~Clk;

  ball_move_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_vs     (frame_vs),
    .keycode      (keycode),
    .wall_req     (wall_req),
    .wall_x       (wall_x),
    .wall_y       (wall_y),
    .wall_ack     (wall_ack),
    .wall_hit     (wall_hit),
    .BallX        (BallX),
    .BallY        (BallY),
    .map          (map),
    .busy         (busy),
    .frame_miss   (frame_miss),
    .wall_timeout (wall_timeout)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Expected outputs for the current cycle
  int exp_x = 320, exp_y = 240, exp_map = 0, exp_wx = 0, exp_wy = 0;
  bit exp_req = 0, exp_busy = 0, exp_miss = 0, exp_to = 0;
  bit miss_pending = 0, check_en = 0;
  int pin_wall = -1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (check_en) begin
      chk("BallX", int'(BallX), exp_x);
      chk("BallY", int'(BallY), exp_y);
      chk("map", int'(map), exp_map);
      chk("busy", int'(busy), int'(exp_busy));
      chk("wall_req", int'(wall_req), int'(exp_req));
      chk("frame_miss", int'(frame_miss), int'(exp_miss));
      chk("wall_timeout", int'(wall_timeout), int'(exp_to));
      if (exp_req) begin
        chk("wall_x", int'(wall_x), exp_wx);
        chk("wall_y", int'(wall_y), exp_wy);
      end
    end
  end

  function automatic int byte_dir(input logic [7:0] b);
    case (b)
      8'h1A:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      8'h07:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int key_dir(input logic [15:0] key);
    int d;
    d = byte_dir(key[7:0]);
    if (d == 0) d = byte_dir(key[15:8]);
    return d;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
    exp_miss     = miss_pending;
    miss_pending = 0;
    exp_to       = 0;
  endtask

  // One frame: tick in cycle 0, ack in cycle 2+k (unless never_ack),
  // optional extra tick at cycle miss_at, optional reset at cycle rst_at.
  task automatic frame(input logic [15:0] key, input int k, input bit hit,
                       input bit never_ack, input int miss_at, input int rst_at);
    int d, nx, ny;
    cyc(); frame_vs = 0; keycode = key; exp_busy = 0; exp_req = 0;
    cyc(); exp_busy = 1;
    d = key_dir(key);
    if (d == 0) begin
      cyc(); frame_vs = 1; exp_busy = 0;
      return;
    end
    nx = exp_x;
    ny = exp_y;
    case (d)
      1: ny = (exp_y - 2 < 0) ? 0 : exp_y - 2;
      2: ny = (exp_y + 2 > 479) ? 479 : exp_y + 2;
      3: nx = (exp_x - 2 < 0) ? 0 : exp_x - 2;
      default: nx = (exp_x + 2 > 639) ? 639 : exp_x + 2;
    endcase
    exp_wx = nx;
    exp_wy = ny;
    for (int c = 0; c < 64; c++) begin
      cyc();
      exp_req = 1; exp_busy = 1;
      if (c == 0) begin
        frame_vs = 1;
        if (pin_wall >= 0) chk("pin_wall_x", int'(wall_x), pin_wall);
      end
      if (c + 2 == miss_at) begin
        frame_vs = 0; miss_pending = 1;
      end
      if (c + 2 == rst_at) begin
        Reset = 1; frame_vs = 1; wall_ack = 0; wall_hit = 0;
        miss_pending = 0;
        cyc();
        Reset = 0;
        exp_req = 0; exp_busy = 0; exp_miss = 0;
        exp_x = 320; exp_y = 240; exp_map = 0;
        return;
      end
      if (!never_ack && c == k) begin
        wall_ack = 1; wall_hit = hit;
        cyc();
        wall_ack = 0; wall_hit = 0; exp_req = 0; frame_vs = 1;
        if (hit) begin
          exp_busy = 0;
          return;
        end
        cyc();
        exp_busy = 0;
        if (nx >= 620) begin
          exp_map = (exp_map + 1) % 4;
          exp_x = 320; exp_y = 240;
        end else begin
          exp_x = nx; exp_y = ny;
        end
        return;
      end
      // A blocked flag without an ack must be ignored
      wall_ack = 0; wall_hit = 1;
      if (never_ack && c == 15) begin
        cyc();
        wall_hit = 0; exp_req = 0; exp_busy = 0; exp_to = 1; frame_vs = 1;
        return;
      end
    end
  endtask

  initial begin
    int exits;
    int m;
    repeat (2) @(posedge Clk);
    #1;
    check_en = 1;
    cyc(); Reset = 0;
    chk("pin_reset_x", int'(BallX), 320);
    cyc();

    frame(16'h0007, 0, 0, 0, -1, -1);
    chk("pin_first_x", int'(BallX), 322);
    chk("pin_first_y", int'(BallY), 240);
    cyc();

    frame(16'h1A04, 0, 1, 0, -1, -1);
    chk("pin_hit_x", int'(BallX), 322);
    frame(16'h0000, 0, 0, 0, -1, -1);
    frame(16'h2C2C, 0, 0, 0, -1, -1);
    frame(16'h1A00, 2, 0, 0, -1, -1);
    chk("pin_hi_up_y", int'(BallY), 238);
    frame(16'h0716, 1, 0, 0, -1, -1);
    chk("pin_lo_down_y", int'(BallY), 240);

    frame(16'h0004, 0, 0, 1, -1, -1);
    chk("pin_timeout_x", int'(BallX), 322);
    cyc();
    frame(16'h0007, 3, 0, 0, -1, -1);
    chk("pin_after_to_x", int'(BallX), 324);

    frame(16'h0004, 5, 0, 0, 4, -1);
    chk("pin_miss_x", int'(BallX), 322);

    for (int i = 0; i < 400 && exp_x > 0; i++) frame(16'h0004, i % 3, 0, 0, -1, -1);
    chk("pin_left_zero", int'(BallX), 0);
    pin_wall = 0;
    frame(16'h0004, 1, 0, 0, -1, -1);
    pin_wall = -1;
    chk("pin_left_clamp", int'(BallX), 0);

    for (int i = 0; i < 400 && exp_y != 479; i++) frame(16'h0016, 0, 0, 0, -1, -1);
    chk("pin_down_clamp", int'(BallY), 479);
    for (int i = 0; i < 400 && exp_y != 1; i++) frame(16'h001A, 0, 0, 0, -1, -1);
    frame(16'h001A, 0, 0, 0, -1, -1);
    chk("pin_up_to_zero", int'(BallY), 0);

    exits = 0;
    for (int i = 0; i < 2000 && exits < 4; i++) begin
      m = exp_map;
      frame(16'h0007, 0, 0, 0, -1, -1);
      if (exp_map != m) begin
        exits++;
        if (exits == 1) begin
          chk("pin_exit_map", int'(map), 1);
          chk("pin_exit_x", int'(BallX), 320);
          chk("pin_exit_y", int'(BallY), 240);
        end
      end
    end
    chk("pin_map_wrap", int'(map), 0);
    chk("pin_exit_count", exits, 4);

    frame(16'h0007, 0, 0, 0, -1, -1);
    frame(16'h0007, 10, 0, 0, -1, 3);
    chk("pin_rst_req", int'(wall_req), 0);
    chk("pin_rst_x", int'(BallX), 320);
    cyc();
    frame(16'h0007, 0, 0, 0, -1, -1);
    chk("pin_post_rst_x", int'(BallX), 322);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
